// File: rtl/rf_pkg.sv
// Shared register-file types: architectural register count, address width and writeback request.
package rf_pkg;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic            valid;
    reg_addr_t       addr;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant searching upward from ptr with wrap; purely combinational.
// The pointer advances past the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               taken,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      next_ptr
);
  logic          found;
  logic [PW-1:0] gidx;
  int            idx;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    gidx     = '0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
    next_ptr = ptr;
    if (taken && found)
      next_ptr = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates NUM_REQ writebacks onto the single register-file write port through a one-cycle output
// register (always accepts, 1 write/cycle) and tracks pending destinations to raise RAW/WAW hazards.
module regfile_wb_scheduler
  import rf_pkg::*;
#(
  parameter int XLEN    = rf_pkg::XLEN,
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*5-1:0]    req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic [4:0]              chk_rs1,
  input  logic [4:0]              chk_rs2,
  output logic                    hazard,
  output logic                    rf_we,
  output logic [4:0]              rf_wa,
  output logic [XLEN-1:0]         rf_wd
);
  localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]       rr_ptr, rr_next;
  logic [NUM_REQ-1:0]  grant;
  logic                xfer;
  wb_req_t             reqs [NUM_REQ];
  wb_req_t             sel;
  logic [NUM_REGS-1:0] pending, pending_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .taken    (xfer),
    .grant    (grant),
    .next_ptr (rr_next)
  );

  assign req_ready = grant;
  assign xfer      = |(grant & req_valid);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i].valid = req_valid[i];
      reqs[i].addr  = req_addr[i*5 +: 5];
      reqs[i].data  = req_data[i*XLEN +: XLEN];
      if (grant[i])
        sel = reqs[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      rf_we  <= 1'b0;
      rf_wa  <= '0;
      rf_wd  <= '0;
    end else begin
      rr_ptr <= rr_next;
      rf_we  <= xfer && (sel.addr != '0);
      if (xfer) begin
        rf_wa <= sel.addr;
        rf_wd <= sel.data;
      end
    end
  end

  // Clear on commit first so a same-edge issue to the same register re-sets it.
  always_comb begin
    pending_nxt = pending;
    if (rf_we)
      pending_nxt[rf_wa] = 1'b0;
    if (issue_valid)
      pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  assign hazard = pending[chk_rs1] | pending[chk_rs2] | (issue_valid & pending[issue_rd]);
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
  localparam int XLEN    = 32;
  localparam int NUM_REQ = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*5-1:0]    req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    issue_valid;
  logic [4:0]              issue_rd, chk_rs1, chk_rs2;
  logic                    hazard;
  logic                    rf_we;
  logic [4:0]              rf_wa;
  logic [XLEN-1:0]         rf_wd;

  int checks = 0;
  int errors = 0;

  regfile_wb_scheduler #(.XLEN(XLEN), .NUM_REQ(NUM_REQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .hazard      (hazard),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]       = a;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    req_addr = '0;
    req_data = '0;
    issue_valid = 1'b0;
    issue_rd = '0;
    chk_rs1 = '0;
    chk_rs2 = '0;
    set_req(0, 5'd5, 32'hDEADBEEF);
    set_req(1, 5'd6, 32'h00000066);
    #2;
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_we", 32'(rf_we), 32'h0);
    check("rst_wa", 32'(rf_wa), 32'h0);
    check("rst_wd", rf_wd, 32'h0);
    check("rst_hazard", 32'(hazard), 32'h0);

    tick();
    rst = 1'b0;
    #1;
    check("first_ready", 32'(req_ready), 32'h1);
    tick();
    check("first_we", 32'(rf_we), 32'h1);
    check("first_wa", 32'(rf_wa), 32'd5);
    check("first_wd", rf_wd, 32'hDEADBEEF);
    check("ptr_after_first", 32'(req_ready), 32'h2);

    // Let requester 1 go once so the pointer is back at 0.
    req_valid = 2'b10;
    tick();
    check("r1_wa", 32'(rf_wa), 32'd6);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check("rr_we", 32'(rf_we), 32'h1);
      check("rr_wa", 32'(rf_wa), (k % 2 == 0) ? 32'd5 : 32'd6);
      check("rr_wd", rf_wd, (k % 2 == 0) ? 32'hDEADBEEF : 32'h00000066);
    end

    // x0 write from requester 1: accepted, discarded.
    set_req(1, 5'd0, 32'h00001234);
    req_valid = 2'b10;
    #1;
    check("x0_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    chk_rs1 = 5'd5;
    #1;
    check("x0_we", 32'(rf_we), 32'h0);
    check("x0_wd", rf_wd, 32'h00001234);
    check("x0_pending", 32'(hazard), 32'h0);
    tick();
    check("idle_we", 32'(rf_we), 32'h0);
    check("idle_wd_hold", rf_wd, 32'h00001234);

    // RAW on x7 cleared by a writeback.
    chk_rs1 = 5'd0;
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    #1;
    check("x7_issue_haz", 32'(hazard), 32'h0);
    tick();
    issue_valid = 1'b0;
    chk_rs1 = 5'd7;
    #1;
    check("x7_raw", 32'(hazard), 32'h1);
    tick();
    check("x7_raw_hold", 32'(hazard), 32'h1);
    set_req(0, 5'd7, 32'h00000077);
    req_valid = 2'b01;
    #1;
    check("x7_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check("x7_we", 32'(rf_we), 32'h1);
    check("x7_wa", 32'(rf_wa), 32'd7);
    check("x7_haz_commit", 32'(hazard), 32'h1);
    tick();
    check("x7_cleared", 32'(hazard), 32'h0);

    // Re-issue to x9 on its commit edge keeps it pending.
    chk_rs1 = 5'd0;
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    set_req(0, 5'd9, 32'h00000099);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    chk_rs2 = 5'd9;
    #1;
    check("x9_we", 32'(rf_we), 32'h1);
    check("x9_wa", 32'(rf_wa), 32'd9);
    check("x9_waw", 32'(hazard), 32'h1);
    tick();
    issue_valid = 1'b0;
    #1;
    check("x9_persist", 32'(hazard), 32'h1);
    tick();
    check("x9_persist2", 32'(hazard), 32'h1);
    chk_rs2 = 5'd0;

    // Reset between accept and commit drops the write and the scoreboard.
    issue_valid = 1'b1;
    issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    chk_rs1 = 5'd3;
    #1;
    check("x3_pending", 32'(hazard), 32'h1);
    set_req(0, 5'd3, 32'h00000033);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    #1;
    check("x3_ptr_moved", 32'(req_ready), 32'h2);
    rst = 1'b1;
    #1;
    check("x3_rst_we", 32'(rf_we), 32'h0);
    check("x3_rst_haz", 32'(hazard), 32'h0);
    check("x3_rst_ptr", 32'(req_ready), 32'h1);
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
    tick();
    check("post_rst_we", 32'(rf_we), 32'h0);
    check("post_rst_haz", 32'(hazard), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
